// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU constants for the fetch stage: NOP encoding, default widths and
// reset PC, plus a helper for sizing occupancy counters.
package instruction_fetch_unit_pkg;

  localparam int          DEF_PC_W     = 8;
  localparam int          DEF_INSTR_W  = 16;
  localparam logic [7:0]  DEF_RESET_PC = 8'h00;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;

  // A counter for 0..depth inclusive needs one bit more than the pointer.
  function automatic int occ_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory port: request/grant for addresses, in-order response.
// A request transfers on a cycle with req && gnt; req/addr hold until granted.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with push/pop/clear and an occupancy count.
// Clear wins over push and pop in the same cycle.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = occ_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; the owner never looks at it while count is 0.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues PCs to instruction memory under a credit limit, buffers
// returned {pc, instr} pairs for IF/ID, and flushes everything on redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              INSTR_W   = DEF_INSTR_W,
  parameter int              BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  instruction_fetch_unit_if.master imem,
  output logic                     if_valid,
  output logic [PC_W-1:0]          if_pc,
  output logic [INSTR_W-1:0]       if_instruction
);
  localparam int CNT_W = occ_cnt_w(BUF_DEPTH);
  localparam int SUM_W = CNT_W + 2;
  localparam int ENT_W = PC_W + INSTR_W;

  logic [PC_W-1:0]  fetch_pc;
  logic [CNT_W-1:0] tag_cnt;
  logic [CNT_W-1:0] buf_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [PC_W-1:0]  tag_head;
  logic [ENT_W-1:0] buf_head;
  logic [SUM_W-1:0] credits_used;
  logic             accept;
  logic             outstanding;
  logic             drop_rsp;
  logic             keep_rsp;
  logic             consume;

  // Killed-but-owed responses still hold a credit until they come back.
  assign credits_used = SUM_W'(tag_cnt) + SUM_W'(drop_cnt) + SUM_W'(buf_cnt);

  // Gated with rst_n so no request is visible while reset is held.
  assign imem.req  = rst_n && !redirect && (credits_used < SUM_W'(BUF_DEPTH));
  assign imem.addr = fetch_pc;
  assign accept    = imem.req && imem.gnt;

  assign outstanding = (tag_cnt != '0) || (drop_cnt != '0);
  assign drop_rsp    = imem.rvalid && (drop_cnt != '0);
  assign keep_rsp    = imem.rvalid && (drop_cnt == '0) && (tag_cnt != '0) && !redirect;

  assign if_valid       = (buf_cnt != '0) && !redirect;
  assign consume        = if_valid && !stall;
  assign if_pc          = if_valid ? buf_head[ENT_W-1:INSTR_W] : '0;
  assign if_instruction = if_valid ? buf_head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);

  fetch_fifo #(.W(PC_W), .DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect),
    .push  (accept),
    .din   (fetch_pc),
    .pop   (keep_rsp),
    .dout  (tag_head),
    .count (tag_cnt)
  );

  fetch_fifo #(.W(ENT_W), .DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_instr_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect),
    .push  (keep_rsp),
    .din   ({tag_head, imem.rdata}),
    .pop   (consume),
    .dout  (buf_head),
    .count (buf_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 1'b1;
    end
  end

  // Every in-flight tag becomes a response to discard; one landing in the
  // redirect cycle itself is already being discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= drop_cnt + tag_cnt - CNT_W'(imem.rvalid && outstanding);
    end else if (drop_rsp) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule
